// File: rtl/sync_down_timer_pkg.sv
// Shared definitions for the loadable down-counter/timer.
// The state encoding is fixed so that debug probes read the same codes in every build.
package sync_down_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sync_down_timer_down_count_reg.sv
// Count register with synchronous clear, parallel load and decrement.
// Priority is clear > load > decrement; is_one_o flags the last count before terminal.
module down_count_reg
   import sync_down_timer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] count_o,
   output logic             is_one_o
);

   localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = {WIDTH{1'b0}};
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i) begin
         count_d = count_q - ONE_C;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count_o  = count_q;
   assign is_one_o = (count_q == ONE_C);

endmodule

// File: rtl/sync_down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// The FSM owns tc/busy/done; the count register lives in down_count_reg.
module sync_down_timer
   import sync_down_timer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] loadVal,
   input  logic             mode,
   input  logic             en,
   output logic [WIDTH-1:0] outBus,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   logic [WIDTH-1:0] reload_q;
   logic             mode_q;
   logic             tc_q;
   logic             busy_q;
   logic             done_q;

   logic             run_s;
   logic             is_one_s;
   logic             reload_hit_s;
   logic             cnt_load_s;
   logic             cnt_dec_s;
   logic [WIDTH-1:0] cnt_val_s;
   logic [WIDTH-1:0] count_s;

   // In auto-reload mode the 1 -> reload step replaces the decrement, so 0 never appears.
   always_comb begin
      run_s        = (state_q == ST_RUN);
      reload_hit_s = run_s && en && is_one_s && mode_q;
      cnt_load_s   = load || reload_hit_s;
      cnt_dec_s    = run_s && en;
      if (load) begin
         cnt_val_s = loadVal;
      end else begin
         cnt_val_s = reload_q;
      end
   end

   down_count_reg #(
      .WIDTH (WIDTH)
   ) u_count (
      .clk        (clk),
      .clr_i      (rst),
      .load_i     (cnt_load_s),
      .load_val_i (cnt_val_s),
      .dec_i      (cnt_dec_s),
      .count_o    (count_s),
      .is_one_o   (is_one_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         reload_q <= {WIDTH{1'b0}};
         mode_q   <= 1'b0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (load) begin
         reload_q <= loadVal;
         mode_q   <= mode;
         tc_q     <= 1'b0;
         done_q   <= 1'b0;
         if (loadVal != {WIDTH{1'b0}}) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
         end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (en && is_one_s) begin
                  tc_q <= 1'b1;
                  if (mode_q) begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end else begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  tc_q <= 1'b0;
               end
            end
            ST_IDLE: begin
               tc_q   <= 1'b0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
            ST_DONE: begin
               tc_q   <= 1'b0;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               tc_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign outBus = count_s;
   assign tc     = tc_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
